// File: rtl/modbus_pkg.sv
// Shared constants and types for the Modbus RTU master: function codes,
// response status encodings, CRC-16/MODBUS parameters and FSM states.
package modbus_pkg;

    localparam logic [7:0]  FUNC_READ_HOLD    = 8'h03;
    localparam logic [7:0]  FUNC_WRITE_SINGLE = 8'h06;
    localparam logic [7:0]  EXC_FLAG          = 8'h80;
    localparam logic [7:0]  BCAST_ADDR        = 8'h00;
    localparam logic [15:0] READ_QTY          = 16'h0001;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    localparam logic [2:0] STAT_OK          = 3'd0;
    localparam logic [2:0] STAT_CRC_ERR     = 3'd1;
    localparam logic [2:0] STAT_TIMEOUT     = 3'd2;
    localparam logic [2:0] STAT_EXCEPTION   = 3'd3;
    localparam logic [2:0] STAT_MISMATCH    = 3'd4;
    localparam logic [2:0] STAT_ILLEGAL_CMD = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_FRAME,
        S_RX_WAIT,
        S_RX_FRAME,
        S_CHECK
    } state_e;

endpackage

// File: rtl/modbus_crc16.sv
// Byte-wise CRC-16/MODBUS update (reflected polynomial, LSB first).
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/modbus_master.sv
// Modbus RTU master: issues a single read (0x03) or write (0x06) request,
// then collects and validates the slave response or times out.
module modbus_master
    import modbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_slave,
    input  logic [7:0]  cmd_func,
    input  logic [15:0] cmd_reg_addr,
    input  logic [15:0] cmd_wr_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic [15:0] rsp_data,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       crc_q, crc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic [15:0]       rsp_data_q, rsp_data_d;

    logic [7:0]        slave_q, slave_d;
    logic [7:0]        func_q, func_d;
    logic [15:0]       reg_q, reg_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [3:0]        rx_len_q, rx_len_d;
    logic              exc_q, exc_d;
    logic              mis_q, mis_d;
    logic [15:0]       rdata_q, rdata_d;

    logic [7:0]        frame_byte;
    logic [7:0]        crc_byte;
    logic [15:0]       crc_next;
    logic              rx_abort;
    logic [15:0]       ok_data;

    // TX and RX never overlap, so one CRC unit serves both directions.
    assign crc_byte = (state_q == S_TX_FRAME) ? frame_byte : rx_data;

    modbus_crc16 u_crc (
        .crc_in  (crc_q),
        .byte_in (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        unique case (byte_cnt_q)
            4'd0:    frame_byte = slave_q;
            4'd1:    frame_byte = func_q;
            4'd2:    frame_byte = reg_q[15:8];
            4'd3:    frame_byte = reg_q[7:0];
            4'd4:    frame_byte = wdata_q[15:8];
            4'd5:    frame_byte = wdata_q[7:0];
            4'd6:    frame_byte = crc_q[7:0];
            default: frame_byte = crc_q[15:8];
        endcase
    end

    assign ok_data = (func_q == FUNC_READ_HOLD) ? rdata_q : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            crc_q        <= CRC_INIT;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= STAT_OK;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            crc_q        <= crc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        slave_q  <= slave_d;
        func_q   <= func_d;
        reg_q    <= reg_d;
        wdata_q  <= wdata_d;
        rx_len_q <= rx_len_d;
        exc_q    <= exc_d;
        mis_q    <= mis_d;
        rdata_q  <= rdata_d;
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_d        = tmo_q;
        crc_d        = crc_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        slave_d      = slave_q;
        func_d       = func_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        rx_len_d     = rx_len_q;
        exc_d        = exc_q;
        mis_d        = mis_q;
        rdata_d      = rdata_q;
        rx_abort     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    slave_d    = cmd_slave;
                    func_d     = cmd_func;
                    reg_d      = cmd_reg_addr;
                    wdata_d    = (cmd_func == FUNC_READ_HOLD) ? READ_QTY : cmd_wr_data;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    crc_d      = CRC_INIT;
                    rx_len_d   = 4'd8;
                    exc_d      = 1'b0;
                    mis_d      = 1'b0;
                    rdata_d    = '0;
                    if (cmd_func == FUNC_READ_HOLD || cmd_func == FUNC_WRITE_SINGLE) begin
                        state_d = S_TX_FRAME;
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = STAT_ILLEGAL_CMD;
                        rsp_data_d   = '0;
                    end
                end
            end
            S_TX_FRAME: begin
                if (tx_ready) begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    // The two CRC bytes themselves are not folded into the CRC.
                    if (byte_cnt_q < 4'd6) crc_d = crc_next;
                    if (byte_cnt_q == 4'd7) begin
                        byte_cnt_d = '0;
                        crc_d      = CRC_INIT;
                        tmo_d      = '0;
                        state_d    = (slave_q == BCAST_ADDR) ? S_CHECK : S_RX_WAIT;
                    end
                end
            end
            S_RX_WAIT, S_RX_FRAME: begin
                if (rx_valid) begin
                    tmo_d      = '0;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    state_d    = (byte_cnt_q >= 4'd2 && byte_cnt_q == rx_len_q - 4'd1)
                                 ? S_CHECK : S_RX_FRAME;
                    unique case (byte_cnt_q)
                        4'd0: rx_abort = (rx_data != slave_q);
                        4'd1: begin
                            if (rx_data == func_q) begin
                                rx_len_d = (func_q == FUNC_READ_HOLD) ? 4'd7 : 4'd8;
                            end else if (rx_data == (func_q | EXC_FLAG)) begin
                                rx_len_d = 4'd5;
                                exc_d    = 1'b1;
                            end else begin
                                rx_abort = 1'b1;
                            end
                        end
                        4'd2: begin
                            if (exc_q)                        rdata_d = {8'h00, rx_data};
                            else if (func_q == FUNC_READ_HOLD) mis_d  = mis_q | (rx_data != 8'h02);
                            else                               mis_d  = mis_q | (rx_data != reg_q[15:8]);
                        end
                        4'd3: begin
                            if (!exc_q && func_q == FUNC_READ_HOLD) rdata_d[15:8] = rx_data;
                            else if (!exc_q)                        mis_d = mis_q | (rx_data != reg_q[7:0]);
                        end
                        4'd4: begin
                            if (!exc_q && func_q == FUNC_READ_HOLD) rdata_d[7:0] = rx_data;
                            else if (!exc_q)                        mis_d = mis_q | (rx_data != wdata_q[15:8]);
                        end
                        4'd5: begin
                            if (!exc_q && func_q == FUNC_WRITE_SINGLE)
                                mis_d = mis_q | (rx_data != wdata_q[7:0]);
                        end
                        default: ;
                    endcase
                    if (rx_abort) begin
                        state_d      = S_IDLE;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = STAT_MISMATCH;
                        rsp_data_d   = '0;
                    end
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        state_d      = S_IDLE;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = STAT_TIMEOUT;
                        rsp_data_d   = '0;
                    end
                end
            end
            S_CHECK: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                // A good frame run through the CRC including its own CRC leaves zero.
                if (slave_q == BCAST_ADDR) begin
                    rsp_status_d = STAT_OK;
                    rsp_data_d   = ok_data;
                end else if (crc_q != 16'h0000) begin
                    rsp_status_d = STAT_CRC_ERR;
                end else if (mis_q) begin
                    rsp_status_d = STAT_MISMATCH;
                end else if (exc_q) begin
                    rsp_status_d = STAT_EXCEPTION;
                    rsp_data_d   = rdata_q;
                end else begin
                    rsp_status_d = STAT_OK;
                    rsp_data_d   = ok_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        tx_valid  = (state_q == S_TX_FRAME);
        tx_data   = (state_q == S_TX_FRAME) ? frame_byte : 8'h00;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_modbus_master.sv
// Directed and randomized bench for modbus_master against a frame-level
// reference model of Modbus RTU request/response handling.
module tb_modbus_master;

    localparam int T = 40;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_slave;
    logic [7:0]  cmd_func;
    logic [15:0] cmd_reg_addr;
    logic [15:0] cmd_wr_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rsp_valid;
    logic [2:0]  rsp_status;
    logic [15:0] rsp_data;
    logic        busy;

    int errs = 0;
    int checks = 0;

    modbus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_slave    (cmd_slave),
        .cmd_func     (cmd_func),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wr_data  (cmd_wr_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rsp_valid    (rsp_valid),
        .rsp_status   (rsp_status),
        .rsp_data     (rsp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial CRC-16/MODBUS: one feedback bit per message bit, LSB first.
    function automatic logic [15:0] crc_ref(input bq_t m);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (m[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ m[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    function automatic bq_t mk(input logic [63:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[(n-1-i)*8 +: 8]);
        return q;
    endfunction

    function automatic bq_t add_crc(input bq_t q);
        logic [15:0] c;
        c = crc_ref(q);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        return q;
    endfunction

    function automatic bq_t build_req(input logic [7:0] s, input logic [7:0] f,
                                      input logic [15:0] r, input logic [15:0] w);
        bq_t q;
        logic [15:0] d;
        d = (f == 8'h03) ? 16'h0001 : w;
        q.push_back(s);
        q.push_back(f);
        q.push_back(r[15:8]);
        q.push_back(r[7:0]);
        q.push_back(d[15:8]);
        q.push_back(d[7:0]);
        return add_crc(q);
    endfunction

    // kinds: 0 good, 1 bad CRC, 2 exception, 3 body mismatch, 4 wrong slave, 5 wrong func
    function automatic bq_t make_rsp(input int kind, input logic [7:0] s, input logic [7:0] f,
                                     input bq_t req);
        bq_t q;
        logic [7:0] x;
        x = 8'd1 << $urandom_range(7);
        if (kind == 2) begin
            q.push_back(s);
            q.push_back(f | 8'h80);
            q.push_back(8'($urandom_range(1, 11)));
        end else if (f == 8'h03) begin
            q.push_back(s);
            q.push_back(f);
            q.push_back((kind == 3) ? (8'h02 ^ x) : 8'h02);
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < 6; i++) q.push_back(req[i]);
            if (kind == 3) q[2 + $urandom_range(3)] ^= x;
        end
        q = add_crc(q);
        if (kind == 1) q[q.size()-1] ^= x;
        if (kind == 4) q[0] ^= x;
        if (kind == 5) q[1] ^= 8'h10;
        return q;
    endfunction

    task automatic model(input logic [7:0] s, input logic [7:0] f, input logic [15:0] w,
                         input bq_t req, input bq_t rsp,
                         output logic [2:0] st, output logic [15:0] d, output int lat,
                         output int nsend, output bit cd);
        bit exc, bad;
        int len;
        bq_t body;
        logic [15:0] c;
        st = 3'd0; d = 16'h0; lat = 1; cd = 1'b0; nsend = 0;
        if (rsp[0] != s) begin
            st = 3'd4; lat = 0; nsend = 1;
            return;
        end
        if (rsp[1] == f) exc = 1'b0;
        else if (rsp[1] == (f | 8'h80)) exc = 1'b1;
        else begin
            st = 3'd4; lat = 0; nsend = 2;
            return;
        end
        len = exc ? 5 : ((f == 8'h03) ? 7 : 8);
        nsend = len;
        for (int i = 0; i < len - 2; i++) body.push_back(rsp[i]);
        c = crc_ref(body);
        bad = 1'b0;
        if (!exc && f == 8'h03 && rsp[2] != 8'h02) bad = 1'b1;
        if (!exc && f == 8'h06)
            for (int i = 2; i < 6; i++) if (rsp[i] != req[i]) bad = 1'b1;
        if (c != {rsp[len-1], rsp[len-2]}) st = 3'd1;
        else if (bad) st = 3'd4;
        else if (exc) begin st = 3'd3; d = {8'h00, rsp[2]}; cd = 1'b1; end
        else begin
            st = 3'd0; cd = 1'b1;
            d = (f == 8'h03) ? {rsp[3], rsp[4]} : w;
        end
    endtask

    task automatic do_cmd(input logic [7:0] s, input logic [7:0] f,
                          input logic [15:0] r, input logic [15:0] w);
        cmd_slave = s; cmd_func = f; cmd_reg_addr = r; cmd_wr_data = w;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_slave = 8'($urandom); cmd_func = 8'($urandom);
        cmd_reg_addr = 16'($urandom); cmd_wr_data = 16'($urandom);
    endtask

    // mode: 0 tx_ready always high, 1 toggling, 2 random
    task automatic run_tx(input int mode, input bq_t exp, input string tag);
        int n = 0;
        int guard = 0;
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        chk({tag, "_tx_rise"}, tx_valid, 1);
        while (n < 8 && guard < 200) begin
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : 1'($urandom_range(1));
            rx_valid = ($urandom_range(3) == 0);
            rx_data  = 8'($urandom);
            if (stalled && tx_valid) chk({tag, "_tx_stable"}, tx_data, held);
            stalled = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    chk($sformatf("%s_tx_b%0d", tag, n), tx_data, exp[n]);
                    n++;
                end else begin
                    stalled = 1'b1;
                    held = tx_data;
                end
            end
            tick();
            guard++;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk({tag, "_tx_count"}, n, 8);
        if (mode == 0) chk({tag, "_tx_cycles"}, guard, 8);
        chk({tag, "_tx_done"}, tx_valid, 0);
    endtask

    task automatic send_rx(input bq_t q, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(2)) tick();
            rx_data = q[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        lat = 0;
        while (!rsp_valid && lat < budget) begin
            tick();
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic dir_txn(input logic [7:0] s, input logic [7:0] f, input logic [15:0] r,
                           input logic [15:0] w, input int mode, input bq_t txe,
                           input bq_t rsp, input int nsend, input logic [2:0] est,
                           input logic [15:0] edata, input int elat, input bit cd,
                           input bit probe, input string tag);
        int lat;
        do_cmd(s, f, r, w);
        run_tx(mode, txe, tag);
        if (probe) begin
            cmd_slave = 8'h05; cmd_func = 8'h03; cmd_valid = 1'b1;
            chk({tag, "_busy_ready"}, {busy, cmd_ready}, 2'b10);
            tick();
            cmd_valid = 1'b0;
        end
        send_rx(rsp, nsend);
        wait_rsp(elat + 8, lat);
        chk({tag, "_latency"}, lat, elat);
        if (lat >= 0) begin
            chk({tag, "_status"}, rsp_status, est);
            if (cd) chk({tag, "_data"}, rsp_data, edata);
            tick();
            chk({tag, "_pulse"}, rsp_valid, 0);
            if (cd) chk({tag, "_data_hold"}, rsp_data, edata);
            chk({tag, "_idle"}, {cmd_ready, busy, tx_valid}, 3'b100);
        end
    endtask

    initial begin : main
        bq_t req, rsp, empty;
        logic [2:0] est;
        logic [15:0] edata;
        int elat, nsend, kind, mode;
        bit cd, quiet;
        logic [7:0] s, f;
        logic [15:0] r, w;

        rst = 1'b1; cmd_valid = 1'b0; cmd_slave = 8'h00; cmd_func = 8'h00;
        cmd_reg_addr = 16'h0; cmd_wr_data = 16'h0; tx_ready = 1'b1;
        rx_valid = 1'b0; rx_data = 8'h00;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        rsp = add_crc(mk(64'h0103021234, 5));
        dir_txn(8'h01, 8'h03, 16'h0000, 16'hBEEF, 0, mk(64'h01030000000184_0A, 8),
                rsp, 7, 3'd0, 16'h1234, 1, 1'b1, 1'b1, "read");

        dir_txn(8'h01, 8'h06, 16'h0001, 16'h0003, 0, mk(64'h010600010003980B, 8),
                mk(64'h010600010003980B, 8), 8, 3'd0, 16'h0003, 1, 1'b1, 1'b0, "write");

        dir_txn(8'h01, 8'h03, 16'h0000, 16'h0000, 0, mk(64'h01030000000184_0A, 8),
                mk(64'h018302C0F1, 5), 5, 3'd3, 16'h0002, 1, 1'b1, 1'b0, "exception");

        dir_txn(8'h01, 8'h06, 16'h0001, 16'h0003, 2, mk(64'h010600010003980B, 8),
                mk(64'h010600010003980A, 8), 8, 3'd1, 16'h0000, 1, 1'b0, 1'b0, "crc_err");

        dir_txn(8'h01, 8'h03, 16'h0000, 16'h0000, 0, mk(64'h01030000000184_0A, 8),
                empty, 0, 3'd2, 16'h0000, T, 1'b0, 1'b0, "timeout");

        dir_txn(8'h01, 8'h03, 16'h0000, 16'h0000, 0, mk(64'h01030000000184_0A, 8),
                mk(64'h0103, 2), 2, 3'd2, 16'h0000, T, 1'b0, 1'b0, "byte_timeout");

        dir_txn(8'h00, 8'h06, 16'h0010, 16'hA5A5, 1, build_req(8'h00, 8'h06, 16'h0010, 16'hA5A5),
                empty, 0, 3'd0, 16'hA5A5, 1, 1'b1, 1'b0, "bcast");

        do_cmd(8'h01, 8'h10, 16'h0000, 16'h0000);
        chk("illegal_rsp", {rsp_valid, rsp_status}, {1'b1, 3'd5});
        chk("illegal_no_tx", {tx_valid, cmd_ready}, 2'b01);
        tick();
        chk("illegal_pulse", rsp_valid, 0);

        do_cmd(8'h02, 8'h06, 16'h0020, 16'h1111);
        tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_mid_in_tx", tx_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        chk("rst_mid_outputs", {tx_valid, cmd_ready, busy, rsp_valid}, 4'b0100);
        chk("rst_mid_tx_data", tx_data, 0);
        quiet = 1'b1;
        repeat (4) begin
            tick();
            if (rsp_valid || tx_valid) quiet = 1'b0;
        end
        chk("rst_mid_quiet", quiet, 1);

        for (int it = 0; it < 20; it++) begin
            s = 8'($urandom_range(1, 247));
            f = $urandom_range(1) ? 8'h03 : 8'h06;
            r = 16'($urandom);
            w = 16'($urandom);
            kind = $urandom_range(5);
            mode = $urandom_range(2);
            req = build_req(s, f, r, w);
            rsp = make_rsp(kind, s, f, req);
            model(s, f, w, req, rsp, est, edata, elat, nsend, cd);
            dir_txn(s, f, r, w, mode, req, rsp, nsend, est, edata, elat, cd, 1'b0,
                    $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/modbus_master.md
MODBUS_MASTER -- requirements
Module: modbus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: response timeout and inter-byte timeout, in clk cycles.
REQ-002 clk  input  1  clock; all logic SHALL be sampled on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  request command present.
REQ-005 cmd_ready  output  1  block ready to accept a command; high only in IDLE.
REQ-006 cmd_slave  input  8  target slave address; 0x00 = broadcast.
REQ-007 cmd_func  input  8  function code; 0x03 = read one holding register, 0x06 = write single register.
REQ-008 cmd_reg_addr  input  16  register address.
REQ-009 cmd_wr_data  input  16  write value; ignored for 0x03.
REQ-010 tx_data / tx_valid / tx_ready  output 8 / output 1 / input 1  byte stream to UART TX.
REQ-011 rx_data / rx_valid  input 8 / input 1  received byte plus 1-cycle strobe.
REQ-012 rsp_valid  output  1  1-cycle completion pulse.
REQ-013 rsp_status  output  3  0 OK, 1 CRC_ERR, 2 TIMEOUT, 3 EXCEPTION, 4 MISMATCH, 5 ILLEGAL_CMD.
REQ-014 rsp_data  output  16  read value, or exception code in [7:0]; held until the next rsp_valid.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 A command SHALL be accepted on the edge where cmd_valid && cmd_ready; all cmd_* fields are latched on that edge.
REQ-017 If cmd_func is neither 0x03 nor 0x06: no TX; rsp_valid on the next cycle with ILLEGAL_CMD.
REQ-018 Request frame, 8 bytes in order: slave, func, reg_hi, reg_lo, data_hi, data_lo, crc_lo, crc_hi.
REQ-019 For 0x03, the data bytes SHALL be quantity 0x0001.
REQ-020 CRC-16/MODBUS: init 0xFFFF, reflected poly 0xA001, LSB byte first; it covers all preceding frame bytes.
REQ-021 tx_valid SHALL rise the cycle after command acceptance.
REQ-022 A byte transfers on each edge where tx_valid && tx_ready.
REQ-023 tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-024 Back-to-back bytes are allowed with no bubble.
REQ-025 States: IDLE -> TX_FRAME -> RX_WAIT -> RX_FRAME -> CHECK -> IDLE.
REQ-026 In TX_FRAME, the transfer of crc_hi moves to RX_WAIT, or to CHECK for broadcast.
REQ-027 Broadcast requests SHALL complete with OK one cycle after crc_hi transfers; no receive phase.
REQ-028 The timeout counter clears on entry to RX_WAIT and on every rx_valid.
REQ-029 When the counter reaches TIMEOUT_CYCLES in RX_WAIT or RX_FRAME: go to IDLE with rsp_valid and TIMEOUT.
REQ-030 Response byte 0 SHALL equal the request slave, else MISMATCH.
REQ-031 Response byte 1 SHALL equal func (normal response) or func|0x80 (exception response), else MISMATCH.
REQ-032 A MISMATCH on byte 0 or 1 terminates immediately: rsp_valid the following cycle.
REQ-033 Expected response lengths: exception 5 bytes; 0x03 7 bytes (byte-count byte 2 SHALL be 0x02, else MISMATCH after CRC); 0x06 8-byte echo.
REQ-034 After the last byte: CHECK for one cycle, then rsp_valid in the next cycle.
REQ-035 Status priority in CHECK: CRC_ERR > MISMATCH (echo or byte-count differs) > EXCEPTION > OK.
REQ-036 OK for 0x03: rsp_data = {byte3, byte4}. OK for 0x06: rsp_data = written value.
REQ-037 EXCEPTION: rsp_data = {8'h00, code}.
REQ-038 rx_valid SHALL be ignored in IDLE, TX_FRAME and CHECK.
REQ-039 cmd_valid while busy SHALL be ignored; no queuing.

Reset
REQ-040 Reset SHALL apply on the next edge regardless of state, aborting any frame with no rsp_valid.
REQ-041 Outputs after reset: cmd_ready 1; tx_valid 0; tx_data 0; rsp_valid 0; rsp_status 0; rsp_data 0; busy 0.
REQ-042 Internal state after reset: state IDLE; CRC accumulator 0xFFFF; byte and timeout counters 0.

Structure
REQ-043 Shared package modbus_pkg SHALL hold: function-code constants, exception flag 0x80, status encodings, CRC init and polynomial constants.
REQ-044 Sub-module modbus_crc16: byte-wise combinational update (crc_in, byte) -> crc_out; TX and RX paths share one instance.
REQ-045 Estimated size: 200-300 RTL lines.

Verification
REQ-046 Read: slave 0x01, reg 0x0000, tx_ready always 1 -> TX 01 03 00 00 00 01 84 0A on 8 consecutive cycles.
REQ-047 Read response: reply 01 03 02 12 34 plus valid CRC -> rsp_valid OK, rsp_data 0x1234.
REQ-048 Write 0x0003 to reg 0x0001 -> TX 01 06 00 01 00 03 98 0B; echo reply with valid CRC -> OK, rsp_data 0x0003.
REQ-049 Read reply 01 83 02 C0 F1 -> EXCEPTION, rsp_data 0x0002.
REQ-050 Reply with last CRC byte corrupted -> CRC_ERR. No reply -> TIMEOUT exactly TIMEOUT_CYCLES after crc_hi transfers.
REQ-051 Broadcast write with tx_ready toggling every cycle -> tx_data stable while stalled, OK with no receive phase; rst asserted mid-TX -> tx_valid 0, cmd_ready 1 next cycle.
